register_file_scoreboard: RTL and testbench

- Parametrised successor to the fixed 32x32 two-read-port RISC-V register file: WIDTH, DEPTH and read-port count are generic.
- Adds async reset of all storage, write-to-read bypass, and a per-register busy scoreboard for a pipelined core.
- Sits between decode (reserve destinations, read sources) and writeback (write results).
- Decode stalls on any read port whose rd_valid is low.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_read_port.sv | 42 ++++
 rtl/register_file_scoreboard.sv | 105 ++++++++++
 tb/tb_register_file_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and RV32 types for the scoreboarded register file.
package rf_pkg;

  localparam int unsigned RF_WIDTH = 32;
  localparam int unsigned RF_DEPTH = 32;

  typedef logic [4:0]  rf_addr_t;
  typedef logic [31:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, write-to-read bypass, then storage.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [WIDTH-1:0]  i_regs [DEPTH],
  input  logic [DEPTH-1:0]  i_busy,
  input  logic              i_wr_ena,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_rd_valid
);

  logic w_is_zero;
  logic w_bypass;

  // Priority: reset / zero register, then in-flight writeback, then stored value
  always_comb begin
    w_is_zero  = (ZERO_REG != 0) && (i_rd_addr == '0);
    // A write during reset never lands, so it must not be forwarded either
    w_bypass   = i_rst_n && i_wr_ena && (i_wr_addr == i_rd_addr);
    o_rd_data  = '0;
    o_rd_valid = 1'b1;
    if (!w_is_zero) begin
      if (w_bypass) begin
        o_rd_data  = i_wr_data;
        o_rd_valid = 1'b1;
      end else begin
        o_rd_data  = i_regs[i_rd_addr];
        o_rd_valid = !i_busy[i_rd_addr];
      end
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Parametrised register file with async-reset storage, bypass and busy scoreboard.
module register_file_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned N_READ   = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_ena,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rsv_ena,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic [N_READ*ADDR_W-1:0] i_rd_addr,
  output logic [N_READ*WIDTH-1:0]  o_rd_data,
  output logic [N_READ-1:0]        o_rd_valid,
  output logic [ADDR_W:0]          o_busy_count
);

  logic [WIDTH-1:0] w_regs [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic [DEPTH-1:0] w_wr_sel;
  logic [DEPTH-1:0] w_rsv_sel;
  logic             w_wr_zero;
  logic             w_rsv_zero;
  logic             w_set;
  logic             w_clr;
  logic [ADDR_W:0]  w_busy_count_d;
  logic [ADDR_W:0]  r_busy_count;

  // One-hot decode of write/reserve targets; the zero register is never selected
  always_comb begin
    w_wr_zero  = (ZERO_REG != 0) && (i_wr_addr == '0);
    w_rsv_zero = (ZERO_REG != 0) && (i_rsv_addr == '0);
    w_wr_sel   = '0;
    w_rsv_sel  = '0;
    if (i_wr_ena && !w_wr_zero) w_wr_sel[i_wr_addr] = 1'b1;
    if (i_rsv_ena && !w_rsv_zero) w_rsv_sel[i_rsv_addr] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    logic [WIDTH-1:0] r_data;
    logic             r_pend;

    // Per-register data flop and FREE/PENDING bit; a reserve outranks a same-cycle write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_data <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_wr_sel[g]) r_data <= i_wr_data;
        if (w_rsv_sel[g]) begin
          r_pend <= 1'b1;
        end else if (w_wr_sel[g]) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_regs[g] = r_data;
    assign w_busy[g] = r_pend;
  end

  // Incremental popcount: at most one set and one clear per cycle
  always_comb begin
    w_set = i_rsv_ena && !w_rsv_zero && !w_busy[i_rsv_addr];
    w_clr = i_wr_ena && !w_wr_zero && w_busy[i_wr_addr] &&
            !(i_rsv_ena && (i_rsv_addr == i_wr_addr));
    w_busy_count_d = r_busy_count + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
  end

  // Busy population register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy_count <= '0;
    end else begin
      r_busy_count <= w_busy_count_d;
    end
  end

  assign o_busy_count = r_busy_count;

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    rf_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG)
    ) u_rd_port (
      .i_rst_n   (i_rst_n),
      .i_rd_addr (i_rd_addr[p*ADDR_W +: ADDR_W]),
      .i_regs    (w_regs),
      .i_busy    (w_busy),
      .i_wr_ena  (i_wr_ena),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_rd_data (o_rd_data[p*WIDTH +: WIDTH]),
      .o_rd_valid(o_rd_valid[p])
    );
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: default 32x32/2-port instance plus a 16-bit/4-port instance.
module tb_register_file_scoreboard;

  logic        clk;
  logic        rst_n;

  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_ena;
  logic [4:0]  rsv_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [5:0]  busy_count;

  logic        b_wr_ena;
  logic [4:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_rsv_ena;
  logic [4:0]  b_rsv_addr;
  logic [19:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_valid;
  logic [5:0]  b_busy_count;

  int n_checks;
  int n_errors;

  string       q_tag [$];
  logic [63:0] q_exp [$];

  // Reference model of the default instance
  logic [31:0] m_reg  [32];
  logic        m_busy [32];

  register_file_scoreboard dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_ena    (wr_ena),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rsv_ena   (rsv_ena),
    .i_rsv_addr  (rsv_addr),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_busy_count(busy_count)
  );

  register_file_scoreboard #(
    .WIDTH (16),
    .N_READ(4)
  ) dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_ena    (b_wr_ena),
    .i_wr_addr   (b_wr_addr),
    .i_wr_data   (b_wr_data),
    .i_rsv_ena   (b_rsv_ena),
    .i_rsv_addr  (b_rsv_addr),
    .i_rd_addr   (b_rd_addr),
    .o_rd_data   (b_rd_data),
    .o_rd_valid  (b_rd_valid),
    .o_busy_count(b_busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    string       tag;
    logic [63:0] exp;
    if (q_exp.size() == 0) begin
      n_errors++;
      $display("FAIL sb_underflow: got %h expected no output at %0t", obs, $time);
    end else begin
      tag = q_tag.pop_front();
      exp = q_exp.pop_front();
      check(tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (a == 5'd0 || !rst_n) return 32'h0;
    if (wr_ena && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic m_valid(input logic [4:0] a);
    if (a == 5'd0 || !rst_n) return 1'b1;
    if (wr_ena && wr_addr == a) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic logic [5:0] m_count();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 6'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_reads();
    sb_push("rd0_data", 64'(m_data(rd_addr[4:0])));
    sb_push("rd0_valid", 64'(m_valid(rd_addr[4:0])));
    sb_push("rd1_data", 64'(m_data(rd_addr[9:5])));
    sb_push("rd1_valid", 64'(m_valid(rd_addr[9:5])));
    sb_pop(64'(rd_data[31:0]));
    sb_pop(64'(rd_valid[0]));
    sb_pop(64'(rd_data[63:32]));
    sb_pop(64'(rd_valid[1]));
  endtask

  task automatic check_count();
    sb_push("busy_count", 64'(m_count()));
    sb_pop(64'(busy_count));
  endtask

  // Drive one cycle from a negedge, check reads mid-cycle and busy_count after the edge
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra,
                       input logic [4:0] a0, input logic [4:0] a1);
    wr_ena   = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_ena  = re;
    rsv_addr = ra;
    rd_addr  = {a1, a0};
    #2;
    check_reads();
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 5'd0) begin
        m_reg[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (re && ra != 5'd0) m_busy[ra] = 1'b1;
    end
    #1;
    check_count();
    @(negedge clk);
  endtask

  // Drop reset between edges and check outputs before any clock arrives
  task automatic async_reset(input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_count();
    wr_ena  = 1'b0;
    rsv_ena = 1'b0;
    rd_addr = {a1, a0};
    #1;
    check_reads();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic b_cycle(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                         input logic re, input logic [4:0] ra, input logic [19:0] addrs,
                         input logic [63:0] exp_d, input logic [3:0] exp_v,
                         input logic [5:0] exp_cnt);
    b_wr_ena   = we;
    b_wr_addr  = wa;
    b_wr_data  = wd;
    b_rsv_ena  = re;
    b_rsv_addr = ra;
    b_rd_addr  = addrs;
    #2;
    sb_push("b_rd_data", exp_d);
    sb_push("b_rd_valid", 64'(exp_v));
    sb_pop(b_rd_data);
    sb_pop(64'(b_rd_valid));
    @(posedge clk);
    #1;
    sb_push("b_busy_count", 64'(exp_cnt));
    sb_pop(64'(b_busy_count));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    wr_ena     = 1'b1;
    wr_addr    = 5'd5;
    wr_data    = 32'hAAAA_5555;
    rsv_ena    = 1'b1;
    rsv_addr   = 5'd31;
    rd_addr    = {5'd31, 5'd5};
    b_wr_ena   = 1'b0;
    b_wr_addr  = '0;
    b_wr_data  = '0;
    b_rsv_ena  = 1'b0;
    b_rsv_addr = '0;
    b_rd_addr  = '0;
    model_reset();

    // Reset state, with strobes active that must have no effect
    #2;
    check_reads();
    check_count();
    @(negedge clk);
    @(negedge clk);
    wr_ena  = 1'b0;
    rsv_ena = 1'b0;
    rst_n   = 1'b1;

    // Bypass of x7, then stored value
    cycle(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);

    // Reserve x3, observe pending, then write it back
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7);
    cycle(1'b1, 5'd3, 32'h12, 1'b0, 5'd0, 5'd3, 5'd3);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);

    // Zero register ignores write and reserve
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7);

    // Same-cycle write and reserve of an already busy x9
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    cycle(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3);

    // Write and reserve to different addresses, including a non-busy write
    cycle(1'b1, 5'd9, 32'h66, 1'b1, 5'd12, 5'd12, 5'd9);
    cycle(1'b1, 5'd20, 32'h77, 1'b0, 5'd0, 5'd20, 5'd12);

    // Reserve x1..x4 then an asynchronous reset
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i), 5'd9);
    end
    async_reset(5'd1, 5'd9);

    // Random traffic on a small address window to force collisions
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    async_reset(5'd2, 5'd5);

    // Second configuration: 16-bit data, four read ports ({p3, p2, p1, p0})
    b_cycle(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, {5'd31, 5'd1, 5'd5, 5'd0},
            64'h0, 4'b1111, 6'd0);
    b_cycle(1'b1, 5'd5, 16'hBEEF, 1'b1, 5'd1, {5'd0, 5'd1, 5'd5, 5'd5},
            {16'h0, 16'h0, 16'hBEEF, 16'hBEEF}, 4'b1111, 6'd1);
    b_cycle(1'b0, 5'd0, 16'h0, 1'b1, 5'd2, {5'd3, 5'd2, 5'd1, 5'd5},
            {16'h0, 16'h0, 16'h0, 16'hBEEF}, 4'b1101, 6'd2);
    b_cycle(1'b1, 5'd1, 16'h1234, 1'b0, 5'd0, {5'd2, 5'd1, 5'd1, 5'd5},
            {16'h0, 16'h1234, 16'h1234, 16'hBEEF}, 4'b0111, 6'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    sb_push("b_rst_busy_count", 64'h0);
    sb_push("b_rst_rd_data", 64'h0);
    sb_push("b_rst_rd_valid", 64'hF);
    sb_pop(64'(b_busy_count));
    sb_pop(b_rd_data);
    sb_pop(64'(b_rd_valid));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
